pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  in  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 id_rs1, id_rs2  in  5 each  source register addresses of the instruction in ID.
REQ-005 id_use1, id_use2  in  1 each  the ID instruction reads rs1 / rs2.
REQ-006 id_halt  in  1  the ID instruction is halting (propagated halt or invalid opcode/size).
REQ-007 ex_rdst, ex_wren, ex_load  in  5, 1, 1  EX-stage destination, write enable, and load flag (MemToReg).
REQ-008 ex_redirect  in  1  branch taken or jump resolved in EX.
REQ-009 mem_rdst, mem_wren  in  5, 1  MEM-stage destination and write enable.
REQ-010 wb_rdst, wb_wren, wb_halt  in  5, 1, 1  WB-stage destination, write enable, and halt marker.
REQ-011 mem_busy  in  1  data memory has not completed its access this cycle.
REQ-012 stall_if, stall_id, stall_ex, stall_mem  out  1 each  hold the PC / IF-ID / ID-EX / EX-MEM register.
REQ-013 flush_id  out  1  load a NOP into the IF/ID register.
REQ-014 bubble_ex  out  1  load a NOP into the ID/EX register.
REQ-015 fwd_a, fwd_b  out  2 each  operand source: 00 register file, 01 EX/MEM result, 10 MEM/WB result.
REQ-016 halted  out  1  the pipeline has drained after a halt.
REQ-017 stall_cnt  out  16  saturating count of cycles in which stall_if is asserted.

Function
REQ-018 A hazard match SHALL require a nonzero destination, the matching write enable, the matching use flag, and equal addresses.
REQ-019 The FSM SHALL have three states: RUN, DRAIN and HALTED.
REQ-020 Priority in RUN SHALL be: mem_busy, then ex_redirect, then load-use, then id_halt.
REQ-021 mem_busy=1 SHALL assert stall_if, stall_id, stall_ex and stall_mem, with no flush or bubble; the state is held.
REQ-022 ex_redirect=1 (with mem_busy=0) SHALL assert flush_id and bubble_ex for one cycle; a simultaneous id_halt SHALL be ignored and the FSM stays in RUN.
REQ-023 Load-use (ex_load=1 and an EX match on rs1 or rs2) SHALL assert stall_if, stall_id and bubble_ex for exactly one cycle.
REQ-024 id_halt=1 with no higher-priority condition SHALL move the FSM RUN->DRAIN at the next edge.
REQ-025 In DRAIN, stall_if and flush_id SHALL be held at 1 and mem_busy SHALL still apply.
REQ-026 In DRAIN, wb_halt=1 SHALL move the FSM to HALTED.
REQ-027 In HALTED, halted=1, stall_if=1, stall_id=1 and flush_id=1 SHALL be held until rst.
REQ-028 Forward selection SHALL be combinational; an EX/MEM match SHALL override a MEM/WB match for the same operand.
REQ-029 stall_cnt SHALL increment on each cycle with stall_if=1 and saturate at 16'hFFFF without wrapping.
REQ-030 All outputs other than halted and stall_cnt SHALL be combinational from the inputs and the state.

Reset
REQ-031 While rst=1 at an edge, the FSM SHALL enter RUN and stall_cnt SHALL clear to 0.
REQ-032 While rst=1, all stall, flush and bubble outputs SHALL be 0, fwd_a=fwd_b=00 and halted=0.
REQ-033 Reset asserted mid-DRAIN or mid-stall SHALL abandon the operation with no residual stall on the following cycle.

Configuration
REQ-034 With macro PIPE_FORWARD_EN defined, operand forwarding SHALL follow REQ-028, and stalls for data hazards SHALL occur only on load-use.
REQ-035 Without PIPE_FORWARD_EN:
- fwd_a and fwd_b SHALL be tied to 00.
- Any EX, MEM or WB match SHALL assert stall_if, stall_id and bubble_ex until the match clears.
- This stall SHALL take the priority slot of load-use.

Verification
REQ-036 Back-to-back dependency: ex_rdst=5, ex_wren=1, ex_load=0, id_rs1=5, id_use1=1 -> fwd_a=01 and no stall (forwarding build); stall_if=1 and bubble_ex=1 (no-forwarding build).
REQ-037 Load-use: ex_load=1, ex_rdst=7, id_rs2=7, id_use2=1 -> stall_if=stall_id=bubble_ex=1 for exactly 1 cycle; stall_cnt goes 0->1.
REQ-038 Redirect versus halt: ex_redirect=1 and id_halt=1 in the same cycle -> flush_id=bubble_ex=1 and the FSM stays in RUN.
REQ-039 Halt drain: id_halt=1 pulse, then wb_halt=1 three cycles later -> DRAIN for 3 cycles, then halted=1 and held until rst.
REQ-040 Memory wait with x0: mem_busy=1 for 4 cycles with ex_rdst=0 matching -> all four stall outputs are 1, no bubble, and stall_cnt increases by 4.
REQ-041 Reset mid-DRAIN and counter saturation: rst during DRAIN -> RUN with all outputs 0 next cycle; holding stall_if with stall_cnt preset to FFFE -> stall_cnt stays at FFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush/bubble generation, operand forward select and halt drain.
// Optional build macro PIPE_FORWARD_EN enables EX/MEM and MEM/WB operand forwarding.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use1,
    input  logic        id_use2,
    input  logic        id_halt,
    input  logic [4:0]  ex_rdst,
    input  logic        ex_wren,
    input  logic        ex_load,
    input  logic        ex_redirect,
    input  logic [4:0]  mem_rdst,
    input  logic        mem_wren,
    input  logic [4:0]  wb_rdst,
    input  logic        wb_wren,
    input  logic        wb_halt,
    input  logic        mem_busy,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        stall_mem,
    output logic        flush_id,
    output logic        bubble_ex,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    state_e      state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] rd, input logic wren,
                                     input logic use_flag, input logic [4:0] rs);
        return wren && use_flag && (rd != 5'd0) && (rd == rs);
    endfunction

    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2, wb_hit1, wb_hit2;
    logic load_use, data_stall;
    logic [1:0] fwd_a_sel, fwd_b_sel;

    always_comb begin
        ex_hit1  = reg_hit(ex_rdst, ex_wren, id_use1, id_rs1);
        ex_hit2  = reg_hit(ex_rdst, ex_wren, id_use2, id_rs2);
        mem_hit1 = reg_hit(mem_rdst, mem_wren, id_use1, id_rs1);
        mem_hit2 = reg_hit(mem_rdst, mem_wren, id_use2, id_rs2);
        wb_hit1  = reg_hit(wb_rdst, wb_wren, id_use1, id_rs1);
        wb_hit2  = reg_hit(wb_rdst, wb_wren, id_use2, id_rs2);
        load_use = ex_load && (ex_hit1 || ex_hit2);
`ifdef PIPE_FORWARD_EN
        data_stall = load_use;
        // The younger producer (EX) holds the newer value and wins.
        fwd_a_sel  = ex_hit1 ? 2'b01 : (mem_hit1 ? 2'b10 : 2'b00);
        fwd_b_sel  = ex_hit2 ? 2'b01 : (mem_hit2 ? 2'b10 : 2'b00);
`else
        data_stall = load_use || ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2 ||
                     wb_hit1 || wb_hit2;
        fwd_a_sel  = 2'b00;
        fwd_b_sel  = 2'b00;
`endif
    end

    always_comb begin
        state_d   = state_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        flush_id  = 1'b0;
        bubble_ex = 1'b0;
        fwd_a     = 2'b00;
        fwd_b     = 2'b00;
        halted    = 1'b0;
        if (!rst) begin
            fwd_a = fwd_a_sel;
            fwd_b = fwd_b_sel;
            unique case (state_q)
                StRun: begin
                    if (mem_busy) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        stall_mem = 1'b1;
                    end else if (ex_redirect) begin
                        // The halting instruction in ID is on the wrong path.
                        flush_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (data_stall) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (id_halt) begin
                        state_d = StDrain;
                    end
                end
                StDrain: begin
                    stall_if = 1'b1;
                    flush_id = 1'b1;
                    if (mem_busy) begin
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        stall_mem = 1'b1;
                    end
                    if (wb_halt) state_d = StHalted;
                end
                StHalted: begin
                    halted   = 1'b1;
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_id = 1'b1;
                end
                default: state_d = StRun;
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_if && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl; expectations follow PIPE_FORWARD_EN if defined.
module tb_pipe_hazard_ctrl;

    logic        clk, rst;
    logic [4:0]  id_rs1, id_rs2, ex_rdst, mem_rdst, wb_rdst;
    logic        id_use1, id_use2, id_halt, ex_wren, ex_load, ex_redirect;
    logic        mem_wren, wb_wren, wb_halt, mem_busy;
    logic        stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex, halted;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use1(id_use1), .id_use2(id_use2),
        .id_halt(id_halt),
        .ex_rdst(ex_rdst), .ex_wren(ex_wren), .ex_load(ex_load), .ex_redirect(ex_redirect),
        .mem_rdst(mem_rdst), .mem_wren(mem_wren),
        .wb_rdst(wb_rdst), .wb_wren(wb_wren), .wb_halt(wb_halt),
        .mem_busy(mem_busy),
        .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
        .flush_id(flush_id), .bubble_ex(bubble_ex), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .halted(halted), .stall_cnt(stall_cnt)
    );

`ifdef PIPE_FORWARD_EN
    localparam bit Fwd = 1'b1;
`else
    localparam bit Fwd = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] ctl;
        logic [15:0] cnt;
        logic        chk_cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] cnt_model = 16'd0;
    logic [10:0] obs_ctl;

    assign obs_ctl = {stall_if, stall_id, stall_ex, stall_mem, flush_id, bubble_ex,
                      fwd_a, fwd_b, halted};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] mk(input logic si, input logic sd, input logic se,
                                       input logic sm, input logic fl, input logic bu,
                                       input logic [1:0] fa, input logic [1:0] fb,
                                       input logic h);
        return {si, sd, se, sm, fl, bu, fa, fb, h};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_inputs();
        id_rs1 = 0; id_rs2 = 0; id_use1 = 0; id_use2 = 0; id_halt = 0;
        ex_rdst = 0; ex_wren = 0; ex_load = 0; ex_redirect = 0;
        mem_rdst = 0; mem_wren = 0; wb_rdst = 0; wb_wren = 0; wb_halt = 0; mem_busy = 0;
    endtask

    // Inputs are already applied; push the expectation, then pop it at the sample point.
    task automatic step(input string tag, input logic [10:0] ctl);
        exp_t e;
        exp_t g;
        e.ctl = ctl;
        e.cnt = cnt_model;
        e.chk_cnt = !rst;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_eq({tag, "/queue_empty"}, 32'd0, 32'd1);
        end else begin
            g = exp_q.pop_front();
            check_eq({tag, "/ctl"}, {21'd0, obs_ctl}, {21'd0, g.ctl});
            if (g.chk_cnt) check_eq({tag, "/cnt"}, {16'd0, stall_cnt}, {16'd0, g.cnt});
        end
        if (rst) cnt_model = 16'd0;
        else if (ctl[10] && cnt_model != 16'hFFFF) cnt_model = cnt_model + 16'd1;
        @(posedge clk);
        #1;
    endtask

    logic [10:0] c_zero, c_data, c_busy, c_redir, c_drain, c_drain_busy, c_halt;
    int          k;

    initial begin
        c_zero       = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
        c_data       = mk(1, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0);
        c_busy       = mk(1, 1, 1, 1, 0, 0, 2'b00, 2'b00, 0);
        c_redir      = mk(0, 0, 0, 0, 1, 1, 2'b00, 2'b00, 0);
        c_drain      = mk(1, 0, 0, 0, 1, 0, 2'b00, 2'b00, 0);
        c_drain_busy = mk(1, 1, 1, 1, 1, 0, 2'b00, 2'b00, 0);
        c_halt       = mk(1, 1, 0, 0, 1, 0, 2'b00, 2'b00, 1);

        clear_inputs();
        rst = 1'b1;
        #1;
        // Reset overrides busy, redirect and a live dependency.
        mem_busy = 1; ex_redirect = 1; ex_rdst = 5; ex_wren = 1; id_rs1 = 5; id_use1 = 1;
        step("rst_quiet", c_zero);
        clear_inputs();
        step("rst_idle", c_zero);
        rst = 1'b0;
        step("idle", c_zero);

        // EX dependency on rs1.
        ex_rdst = 5; ex_wren = 1; id_rs1 = 5; id_use1 = 1;
        step("b2b_ex_rs1", Fwd ? mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0) : c_data);
        clear_inputs();
        mem_rdst = 3; mem_wren = 1; id_rs2 = 3; id_use2 = 1;
        step("mem_rs2", Fwd ? mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0) : c_data);
        clear_inputs();
        ex_rdst = 4; ex_wren = 1; mem_rdst = 4; mem_wren = 1; id_rs1 = 4; id_use1 = 1;
        step("ex_over_mem", Fwd ? mk(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0) : c_data);
        clear_inputs();
        wb_rdst = 9; wb_wren = 1; id_rs1 = 9; id_use1 = 1;
        step("wb_rs1", Fwd ? c_zero : c_data);
        clear_inputs();
        ex_rdst = 6; ex_wren = 1; id_rs1 = 6; id_use1 = 0;
        step("no_use_flag", c_zero);
        clear_inputs();
        ex_rdst = 6; ex_wren = 0; id_rs1 = 6; id_use1 = 1;
        step("no_wren", c_zero);
        clear_inputs();
        ex_rdst = 0; ex_wren = 1; ex_load = 1; id_rs1 = 0; id_use1 = 1;
        step("x0_no_hit", c_zero);
        clear_inputs();

        // Load-use on rs2: one stall cycle, then the bubble clears the EX stage.
        ex_load = 1; ex_rdst = 7; ex_wren = 1; id_rs2 = 7; id_use2 = 1;
        step("load_use", Fwd ? mk(1, 1, 0, 0, 0, 1, 2'b00, 2'b01, 0) : c_data);
        clear_inputs();
        step("load_use_after", c_zero);

        // Redirect beats halt and load-use; FSM stays in RUN.
        ex_redirect = 1; id_halt = 1;
        step("redir_vs_halt", c_redir);
        clear_inputs();
        step("redir_stay_run", c_zero);
        ex_redirect = 1; ex_load = 1; ex_rdst = 8; ex_wren = 1; id_rs1 = 8; id_use1 = 1;
        step("redir_vs_lu", Fwd ? mk(0, 0, 0, 0, 1, 1, 2'b01, 2'b00, 0) : c_redir);
        clear_inputs();
        mem_busy = 1; ex_redirect = 1; id_halt = 1;
        step("busy_vs_redir", c_busy);
        clear_inputs();
        step("busy_hold_run", c_zero);

        // Memory wait with an x0 "match": four full stalls, no bubble.
        for (int i = 0; i < 4; i++) begin
            mem_busy = 1; ex_rdst = 0; ex_wren = 1; ex_load = 1; id_rs1 = 0; id_use1 = 1;
            step($sformatf("mem_wait%0d", i), c_busy);
        end
        clear_inputs();
        step("mem_wait_done", c_zero);

        // Halt drain: id_halt pulse, DRAIN for 3 cycles, wb_halt on the third.
        id_halt = 1;
        step("halt_issue", c_zero);
        clear_inputs();
        step("drain0", c_drain);
        mem_busy = 1;
        step("drain1_busy", c_drain_busy);
        clear_inputs();
        wb_halt = 1;
        step("drain2_wbhalt", c_drain);
        clear_inputs();
        step("halted0", c_halt);
        id_halt = 1; ex_redirect = 1; mem_busy = 1;
        step("halted1_noisy", c_halt);
        clear_inputs();

        // Saturation: HALTED holds stall_if every cycle.
        k = 32'h0000FFFE - int'(cnt_model);
        repeat (k) @(posedge clk);
        #1;
        cnt_model = 16'hFFFE;
        step("sat_fffe", c_halt);
        step("sat_ffff", c_halt);
        step("sat_hold", c_halt);

        rst = 1;
        step("rst_from_halt", c_zero);
        rst = 0;
        step("run_after_halt", c_zero);

        // Reset mid-DRAIN while memory is busy.
        id_halt = 1;
        step("halt_issue2", c_zero);
        clear_inputs();
        step("drain_pre_rst", c_drain);
        rst = 1; mem_busy = 1;
        step("rst_mid_drain", c_zero);
        rst = 0; mem_busy = 0;
        step("after_rst_drain", c_zero);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
